ps2_scan_sequencer: RTL and testbench
=====================================

Name: ps2_scan_sequencer

Overview:
- Controller that drains the PS/2 receiver FIFO through its ready/nextdata_n handshake.
- Parses the raw scancode stream (set 2: E0 extended prefix, F0 break prefix) into single key events (code, extended flag, make/break).
- Tracks modifier state (shift, ctrl, caps lock) and suppresses typematic auto-repeat.
- Sits between the ps2 receiver and the ASCII translation/display logic, delivering one event per valid/ack handshake.

Parameters:
- TIMEOUT_CYCLES, 2_000_000: max cycles allowed between a prefix byte and its completing byte before the sequence is abandoned.
- TO_W, 21: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.
- SUPPRESS_REPEAT, 1: 1 = drop a make event whose code and ext match the currently held key.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_ready  in  1  receiver FIFO non-empty; rx_data is valid
- rx_data  in  8  byte at the receiver FIFO read pointer
- rx_nextdata_n  out  1  active-low one-cycle pop strobe to the receiver
- ev_valid  out  1  key event available
- ev_ack  in  1  consumer accepts the event (transfer when ev_valid & ev_ack)
- ev_code  out  8  scancode, prefixes stripped
- ev_ext  out  1  event carried an E0 prefix
- ev_break  out  1  1 = key release, 0 = key press
- mod_shift  out  1  either shift held (0x12 or 0x59, non-ext)
- mod_ctrl  out  1  either ctrl held (0x14, ext or non-ext)
- caps_lock  out  1  toggles on each caps (0x58) make
- err_timeout  out  1  sticky; set when a prefix times out
- drop_cnt  out  8  saturating count of suppressed repeats

Behaviour:
- Reset (rst=1 at a clk edge), all outputs:
  - rx_nextdata_n=1, ev_valid=0; ev_code, ev_ext, ev_break=0
  - mod_shift, mod_ctrl, caps_lock=0; err_timeout=0; drop_cnt=0
  - FSM to IDLE; held-key register cleared (held_v=0).
  - Reset mid-sequence discards any partial prefix with no event emitted.
- Fetch handshake:
  - Pop only in IDLE, PRE_E0, PRE_F0 and PRE_E0F0, when rx_ready=1 and ev_valid=0 (a pending event blocks fetch; this is backpressure).
  - Cycle N: byte latched internally, rx_nextdata_n=0 for exactly one cycle.
  - Cycle N+1: state WAIT, rx_nextdata_n=1, rx_ready/rx_data ignored while the receiver pointer settles.
  - Cycle N+2: return to the parse state, so the next byte may be popped at N+2.
- FSM states: IDLE, PRE_E0, PRE_F0, PRE_E0F0, WAIT (WAIT returns to the parse state chosen at latch time). Transitions on the latched byte b:
  - IDLE: b=E0 -> PRE_E0; b=F0 -> PRE_F0; otherwise emit make(b, ext=0).
  - PRE_E0: b=F0 -> PRE_E0F0; b=E0 -> stay PRE_E0; otherwise emit make(b, ext=1).
  - PRE_F0: emit break(b, ext=0).
  - PRE_E0F0: emit break(b, ext=1).
  - Bytes AA, FA, EE, FE, 00 and FF in any state: discarded, FSM returns to IDLE, no event.
  - Emitting returns the FSM to IDLE.
- Emit:
  - ev_valid rises the cycle after the latch; ev_code, ev_ext and ev_break stay stable until ev_valid & ev_ack.
  - ev_valid falls on the cycle after the ack.
- Modifiers update in the same cycle ev_valid rises, independent of ack.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - A make matching {held_code, held_ext} with held_v=1 produces no event and increments drop_cnt, saturating at 255.
  - A make that is not suppressed loads the held register.
  - A break matching the held register clears held_v.
- Timeout:
  - The counter resets on entry to any PRE_* state and increments each cycle spent there, including WAIT cycles after that entry.
  - Reaching TIMEOUT_CYCLES -> FSM to IDLE, err_timeout=1 (cleared only by rst).
- Simultaneous events: ack and a new rx_ready in the same cycle -> the pop happens no earlier than the following cycle, because the ev_valid=0 check uses the registered value.

Decomposition:
- Package ps2_pkg holds:
  - constants SC_PREFIX_EXT=8'hE0, SC_PREFIX_BRK=8'hF0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CTRL=8'h14, SC_CAPS=8'h58
  - the control-byte list
  - the FSM state enum
- One sub-module, ps2_mod_tracker: consumes the emitted event and produces mod_shift, mod_ctrl, caps_lock and the repeat-suppression decision.
- Timeout counter and fetch FSM stay in the top.

Test Plan:
- Bytes 1C, F0, 1C with rx_ready held and ev_ack=1 -> events {1C, ext=0, break=0} then {1C, ext=0, break=1}. Exactly 3 low pulses on rx_nextdata_n, spaced no closer than 2 cycles.
- E0, 75, E0, F0, 75 -> events {75, ext=1, break=0} and {75, ext=1, break=1}; no event for prefix bytes.
- 12, 1C, 1C, 1C, F0, 1C, F0, 12 -> mod_shift=1 after the first event. One 1C make and one 1C break are emitted; drop_cnt=2; mod_shift=0 at the end.
- 58, F0, 58, 58, F0, 58 -> caps_lock goes 0 -> 1 -> 0.
- E0 then no bytes for TIMEOUT_CYCLES (set to 100) -> FSM back to IDLE, err_timeout=1. A following 1C yields {1C, ext=0}.
- Hold ev_ack=0 after the first event while rx_ready=1 -> rx_nextdata_n stays 1 and the event is stable. Assert rst mid PRE_F0 -> all outputs return to reset values.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 set-2 scancode constants, control-byte list and the
// fetch/parse FSM state encoding shared by the scan sequencer.
package ps2_pkg;

  localparam logic [7:0] SC_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] SC_PREFIX_BRK = 8'hF0;
  localparam logic [7:0] SC_LSHIFT     = 8'h12;
  localparam logic [7:0] SC_RSHIFT     = 8'h59;
  localparam logic [7:0] SC_CTRL       = 8'h14;
  localparam logic [7:0] SC_CAPS       = 8'h58;

  localparam int N_CTRL = 6;
  localparam logic [7:0] CTRL_BYTES [N_CTRL] = '{
    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE_E0,
    ST_PRE_F0,
    ST_PRE_E0F0,
    ST_WAIT
  } state_t;

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CTRL; i++) begin
      if (b == CTRL_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_scan_sequencer_mod_tracker.sv
// Modifier/caps state and typematic repeat suppression driven by
// candidate key events from the scan sequencer.
module ps2_mod_tracker
  import ps2_pkg::*;
#(
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cand,
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       brk,
  output logic       suppress,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       caps_lock,
  output logic [7:0] drop_cnt
);

  logic [7:0] held_code;
  logic       held_ext;
  logic       held_v;
  logic       lshift, rshift;
  logic       lctrl, rctrl;
  logic       take;
  logic       held_hit;

  always_comb begin
    held_hit = held_v && (held_code == code) && (held_ext == ext);
    suppress = SUPPRESS_REPEAT && cand && !brk && held_hit;
    take     = cand && !suppress;
  end

  assign mod_shift = lshift | rshift;
  assign mod_ctrl  = lctrl | rctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_code <= 8'h00;
      held_ext  <= 1'b0;
      held_v    <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      caps_lock <= 1'b0;
      drop_cnt  <= 8'h00;
    end else begin
      if (suppress && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (take) begin
        if (!ext && code == SC_LSHIFT) lshift <= !brk;
        if (!ext && code == SC_RSHIFT) rshift <= !brk;
        if (code == SC_CTRL) begin
          if (ext) rctrl <= !brk;
          else     lctrl <= !brk;
        end
        if (!brk && !ext && code == SC_CAPS)
          caps_lock <= !caps_lock;
        // Only the most recent make is tracked as the repeat candidate.
        if (!brk) begin
          held_v    <= 1'b1;
          held_code <= code;
          held_ext  <= ext;
        end else if (held_hit) begin
          held_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Drains the PS/2 receiver FIFO, parses E0/F0 prefixed set-2 scancodes
// and presents one key event per valid/ack handshake.
module ps2_scan_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 2_000_000,
  parameter int TO_W            = 21,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_nextdata_n,
  output logic       ev_valid,
  input  logic       ev_ack,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       caps_lock,
  output logic       err_timeout,
  output logic [7:0] drop_cnt
);

  state_t          state, state_n;
  state_t          ret, ret_n;
  logic [TO_W-1:0] to_cnt;
  logic            parse, to_active, to_hit, pop;
  logic            emit, emit_ext, emit_brk;
  logic            cand, suppress, fire;

  function automatic logic is_pre(input state_t s);
    return s inside {ST_PRE_E0, ST_PRE_F0, ST_PRE_E0F0};
  endfunction

  always_comb begin
    parse     = is_pre(state) || state == ST_IDLE;
    to_active = is_pre(state) || (state == ST_WAIT && is_pre(ret));
    to_hit    = to_active &&
                (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    // Registered ev_valid gates the pop, so a pending event blocks fetch.
    pop       = parse && rx_ready && !ev_valid && !to_hit;
  end

  assign rx_nextdata_n = !pop;

  always_comb begin
    ret_n    = ST_IDLE;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (!is_ctrl_byte(rx_data)) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_data == SC_PREFIX_EXT)      ret_n = ST_PRE_E0;
          else if (rx_data == SC_PREFIX_BRK) ret_n = ST_PRE_F0;
          else                               emit  = 1'b1;
        end
        ST_PRE_E0: begin
          if (rx_data == SC_PREFIX_BRK)      ret_n = ST_PRE_E0F0;
          else if (rx_data == SC_PREFIX_EXT) ret_n = ST_PRE_E0;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        ST_PRE_F0: begin
          emit     = 1'b1;
          emit_brk = 1'b1;
        end
        ST_PRE_E0F0: begin
          emit     = 1'b1;
          emit_ext = 1'b1;
          emit_brk = 1'b1;
        end
        default: ;
      endcase
    end
    cand = pop && emit;
    fire = cand && !suppress;
  end

  always_comb begin
    state_n = state;
    if (to_hit)                state_n = ST_IDLE;
    else if (pop)              state_n = ST_WAIT;
    else if (state == ST_WAIT) state_n = ret;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret    <= ST_IDLE;
      to_cnt <= '0;
    end else begin
      if (pop) ret <= ret_n;
      if (pop && is_pre(ret_n)) to_cnt <= '0;
      else if (to_active)       to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid    <= 1'b0;
      ev_code     <= 8'h00;
      ev_ext      <= 1'b0;
      ev_break    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (fire) begin
        ev_valid <= 1'b1;
        ev_code  <= rx_data;
        ev_ext   <= emit_ext;
        ev_break <= emit_brk;
      end else if (ev_valid && ev_ack) begin
        ev_valid <= 1'b0;
      end
      if (to_hit) err_timeout <= 1'b1;
    end
  end

  ps2_mod_tracker #(
    .SUPPRESS_REPEAT(SUPPRESS_REPEAT)
  ) u_mod (
    .clk      (clk),
    .rst      (rst),
    .cand     (cand),
    .code     (rx_data),
    .ext      (emit_ext),
    .brk      (emit_brk),
    .suppress (suppress),
    .mod_shift(mod_shift),
    .mod_ctrl (mod_ctrl),
    .caps_lock(caps_lock),
    .drop_cnt (drop_cnt)
  );

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed scoreboard bench for ps2_scan_sequencer with a small
// receiver-FIFO model and a 100-cycle prefix timeout.
module tb_ps2_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_nextdata_n;
  logic       ev_valid;
  logic       ev_ack;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       mod_shift;
  logic       mod_ctrl;
  logic       caps_lock;
  logic       err_timeout;
  logic [7:0] drop_cnt;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  logic [7:0] rxq [$];
  ev_t        expq [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pops = 0;
  int last_pop = -100;
  int min_gap = 1000;
  bit pop_seen = 1'b0;

  always #5 clk = ~clk;

  ps2_scan_sequencer #(
    .TIMEOUT_CYCLES(100),
    .TO_W(8),
    .SUPPRESS_REPEAT(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_nextdata_n(rx_nextdata_n),
    .ev_valid     (ev_valid),
    .ev_ack       (ev_ack),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_break     (ev_break),
    .mod_shift    (mod_shift),
    .mod_ctrl     (mod_ctrl),
    .caps_lock    (caps_lock),
    .err_timeout  (err_timeout),
    .drop_cnt     (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop strobe sampled at the edge the DUT latches on.
  always @(posedge clk) begin
    cyc++;
    if (!rst && rx_nextdata_n === 1'b0) begin
      pop_seen = 1'b1;
      pops++;
      if (cyc - last_pop < min_gap) min_gap = cyc - last_pop;
      last_pop = cyc;
    end
  end

  always @(negedge clk) begin
    if (pop_seen && rxq.size() != 0) rxq.delete(0);
    pop_seen = 1'b0;
    rx_ready = rxq.size() != 0;
    rx_data  = rx_ready ? rxq[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ack) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_event observed=%0h expected=none",
               {ev_code, ev_ext, ev_break});
      end else begin
        chk("event", {22'd0, ev_code, ev_ext, ev_break},
            {22'd0, expq[0]});
        expq.delete(0);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic e,
                           input logic k);
    expq.push_back('{code: c, ext: e, brk: k});
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (rxq.size() == 0 && expq.size() == 0 && !ev_valid)
        done = 1'b1;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (!done) begin
      miscompares++;
      $error("FAIL %s drain observed=rx%0d/ev%0d expected=0/0",
             tag, rxq.size(), expq.size());
    end
  endtask

  initial begin
    int p0;
    bit seen;
    rst = 1'b1;
    ev_ack = 1'b1;
    rx_ready = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_nextdata_n", rx_nextdata_n, 1);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_fields", {ev_code, ev_ext, ev_break}, 0);
    chk("rst_mods", {mod_shift, mod_ctrl, caps_lock}, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // make/break of 1C with exactly three pops
    p0 = pops;
    min_gap = 1000;
    send(8'h1C); send(8'hF0); send(8'h1C);
    expect_ev(8'h1C, 0, 0);
    expect_ev(8'h1C, 0, 1);
    drain("t1", 60);
    chk("t1_pops", pops - p0, 3);
    chk("t1_gap_ge2", min_gap >= 2, 1);

    // extended make/break
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    expect_ev(8'h75, 1, 0);
    expect_ev(8'h75, 1, 1);
    drain("t2", 60);

    // shift + typematic repeat suppression
    send(8'h12);
    expect_ev(8'h12, 0, 0);
    drain("t3a", 30);
    chk("t3_shift_on", mod_shift, 1);
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    expect_ev(8'h1C, 0, 0);
    expect_ev(8'h1C, 0, 1);
    expect_ev(8'h12, 0, 1);
    drain("t3b", 80);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_shift_off", mod_shift, 0);

    // caps lock toggling
    send(8'h58);
    expect_ev(8'h58, 0, 0);
    drain("t4a", 30);
    chk("t4_caps_on", caps_lock, 1);
    send(8'hF0); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    expect_ev(8'h58, 0, 1);
    expect_ev(8'h58, 0, 0);
    expect_ev(8'h58, 0, 1);
    drain("t4b", 60);
    chk("t4_caps_off", caps_lock, 0);
    chk("t4_drop", drop_cnt, 2);

    // abandoned E0 prefix
    send(8'hE0);
    repeat (50) @(negedge clk);
    chk("t5_err_early", err_timeout, 0);
    repeat (80) @(negedge clk);
    chk("t5_err_set", err_timeout, 1);
    send(8'h1C);
    expect_ev(8'h1C, 0, 0);
    drain("t5", 30);

    // backpressure: pending event blocks further pops
    ev_ack = 1'b0;
    send(8'h29); send(8'hF0); send(8'h29);
    expect_ev(8'h29, 0, 0);
    expect_ev(8'h29, 0, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ev_valid) seen = 1'b1;
    end
    chk("t6_ev_seen", seen, 1);
    p0 = pops;
    repeat (10) @(negedge clk);
    chk("t6_no_pop", pops - p0, 0);
    chk("t6_hold_valid", ev_valid, 1);
    chk("t6_hold_fields", {ev_code, ev_ext, ev_break}, {8'h29, 2'b00});
    ev_ack = 1'b1;
    drain("t6", 60);

    // reset in the middle of an F0 prefix
    send(8'h12);
    expect_ev(8'h12, 0, 0);
    drain("t7a", 30);
    chk("t7_shift_pre", mod_shift, 1);
    send(8'hF0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    rxq.delete();
    repeat (2) @(negedge clk);
    chk("t7_nextdata_n", rx_nextdata_n, 1);
    chk("t7_ev_valid", ev_valid, 0);
    chk("t7_ev_fields", {ev_code, ev_ext, ev_break}, 0);
    chk("t7_mods", {mod_shift, mod_ctrl, caps_lock}, 0);
    chk("t7_err", err_timeout, 0);
    chk("t7_drop", drop_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    send(8'h1C);
    expect_ev(8'h1C, 0, 0);
    drain("t7b", 30);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
